// File: rtl/hdmi_tmds_encoder.sv
// DVI TMDS encoder: three channels, transition minimisation then DC balance.
// Two-stage pipeline; control tokens during blanking, sync carried on c0.
module hdmi_tmds_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        de_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [23:0] rgb_in,
  output logic [9:0]  tmds_c0,
  output logic [9:0]  tmds_c1,
  output logic [9:0]  tmds_c2
);

  localparam logic [9:0] CTL00 = 10'h354;

  function automatic logic [3:0] ones(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++)
      n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [8:0] tm(input logic [7:0] d);
    logic [8:0] q;
    logic [3:0] n;
    logic       xn;
    n    = ones(d);
    xn   = (n > 4'd4) || ((n == 4'd4) && !d[0]);
    q    = 9'd0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++)
      q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~xn;
    return q;
  endfunction

  function automatic logic [9:0] token(input logic [1:0] c);
    logic [9:0] t;
    t = CTL00;
    unique case (c)
      2'b00: t = 10'h354;
      2'b01: t = 10'h0ab;
      2'b10: t = 10'h154;
      2'b11: t = 10'h2ab;
    endcase
    return t;
  endfunction

  logic [7:0] d_in [3];
  logic [9:0] chars [3];
  logic       de_r;
  logic [1:0] ctl_r;

  assign d_in[0] = rgb_in[7:0];
  assign d_in[1] = rgb_in[15:8];
  assign d_in[2] = rgb_in[23:16];

  always_ff @(posedge clk) begin
    if (rst) begin
      de_r  <= 1'b0;
      ctl_r <= 2'b00;
    end else begin
      de_r  <= de_in;
      ctl_r <= {vsync_in, hsync_in};
    end
  end

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    logic [8:0] qm;
    logic [8:0] qm_r;
    logic [3:0] n1_r;
    logic [4:0] cnt;
    logic [4:0] cnt_nx;
    logic [4:0] diff;
    logic [9:0] data_nx;
    logic [9:0] out_r;
    logic [1:0] c;
    logic       q8;
    logic       case_a;
    logic       case_b;

    assign qm = tm(d_in[ch]);
    assign c  = (ch == 0) ? ctl_r : 2'b00;
    assign q8 = qm_r[8];

    always_ff @(posedge clk) begin
      if (rst) begin
        qm_r <= 9'd0;
        n1_r <= 4'd0;
      end else begin
        qm_r <= qm;
        n1_r <= ones(qm[7:0]);
      end
    end

    // cnt is two's complement; diff = N1-N0 wraps the same way
    always_comb begin
      diff    = {n1_r, 1'b0} - 5'd8;
      case_a  = (cnt == 5'd0) || (n1_r == 4'd4);
      case_b  = (!cnt[4] && (n1_r > 4'd4)) ||
                (cnt[4] && (n1_r < 4'd4));
      data_nx = 10'd0;
      cnt_nx  = cnt;
      if (case_a) begin
        data_nx = {~q8, q8, q8 ? qm_r[7:0] : ~qm_r[7:0]};
        cnt_nx  = q8 ? cnt + diff : cnt - diff;
      end else if (case_b) begin
        data_nx = {1'b1, q8, ~qm_r[7:0]};
        cnt_nx  = cnt + {3'b000, q8, 1'b0} - diff;
      end else begin
        data_nx = {1'b0, q8, qm_r[7:0]};
        cnt_nx  = cnt + diff - {3'b000, ~q8, 1'b0};
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        out_r <= CTL00;
        cnt   <= 5'd0;
      end else if (!de_r) begin
        out_r <= token(c);
        cnt   <= 5'd0;
      end else begin
        out_r <= data_nx;
        cnt   <= cnt_nx;
      end
    end

    assign chars[ch] = out_r;
  end

  assign tmds_c0 = chars[0];
  assign tmds_c1 = chars[1];
  assign tmds_c2 = chars[2];

endmodule

// File: tb/tb_hdmi_tmds_encoder.sv
// Scoreboard bench for hdmi_tmds_encoder: directed vectors plus a
// round-trip 4x4 frame through an independent TMDS decoder.
module tb_hdmi_tmds_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        de_in = 1'b0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic [23:0] rgb_in = 24'h0;
  logic [9:0]  tmds_c0, tmds_c1, tmds_c2;

  hdmi_tmds_encoder dut (
    .clk      (clk),
    .rst      (rst),
    .de_in    (de_in),
    .hsync_in (hsync_in),
    .vsync_in (vsync_in),
    .rgb_in   (rgb_in),
    .tmds_c0  (tmds_c0),
    .tmds_c1  (tmds_c1),
    .tmds_c2  (tmds_c2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          dec;
    logic [29:0] exp;
    logic [23:0] rgb;
    string       nm;
  } ent_t;

  ent_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [9:0] tok(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b00:   t = 10'h354;
      2'b01:   t = 10'h0ab;
      2'b10:   t = 10'h154;
      default: t = 10'h2ab;
    endcase
    return t;
  endfunction

  function automatic logic [7:0] dec8(input logic [9:0] c);
    logic [7:0] d;
    logic [7:0] o;
    d    = c[9] ? ~c[7:0] : c[7:0];
    o    = 8'd0;
    o[0] = d[0];
    for (int i = 1; i < 8; i++)
      o[i] = c[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return o;
  endfunction

  function automatic logic [29:0] all3(input logic [9:0] v);
    return {v, v, v};
  endfunction

  // monitor: output for inputs driven in cycle k is visible in cycle k+2
  always @(negedge clk) begin
    while (q.size() != 0 && q[0].cyc + 2 == cyc) begin
      ent_t e;
      logic [29:0] got;
      logic [23:0] px;
      e   = q.pop_front();
      got = {tmds_c2, tmds_c1, tmds_c0};
      checks++;
      if (e.dec) begin
        px = {dec8(tmds_c2), dec8(tmds_c1), dec8(tmds_c0)};
        if (px !== e.rgb) begin
          failures++;
          $display("FAIL %s cyc=%0d decoded=%h expected=%h chars=%h",
                   e.nm, cyc, px, e.rgb, got);
        end
      end else if (got !== e.exp) begin
        failures++;
        $display("FAIL %s cyc=%0d got=%h expected=%h",
                 e.nm, cyc, got, e.exp);
      end
    end
  end

  task automatic step(input logic r, input logic d, input logic vs,
                      input logic hs, input logic [23:0] px,
                      input bit dc, input logic [29:0] e,
                      input string nm);
    ent_t en;
    @(posedge clk);
    #1;
    rst      = r;
    de_in    = d;
    vsync_in = vs;
    hsync_in = hs;
    rgb_in   = px;
    en.cyc   = cyc;
    en.dec   = dc;
    en.exp   = e;
    en.rgb   = px;
    en.nm    = nm;
    q.push_back(en);
  endtask

  task automatic blank(input logic [1:0] s, input string nm);
    step(0, 0, s[1], s[0], 24'h5a5a5a, 0,
         {10'h354, 10'h354, tok(s)}, nm);
  endtask

  initial begin
    logic [23:0] px;
    logic [7:0]  v;

    step(1, 1, 1, 1, 24'hdeadbe, 0, all3(10'h354), "reset0");
    step(1, 1, 0, 1, 24'h123456, 0, all3(10'h354), "reset1");

    blank(2'b00, "ctl00");
    blank(2'b01, "ctl01");
    blank(2'b10, "ctl10");
    blank(2'b11, "ctl11");
    blank(2'b00, "ctl00b");

    step(0, 1, 1, 1, 24'h000000, 0, all3(10'h100), "dc0");
    step(0, 1, 0, 0, 24'h000000, 0, all3(10'h3ff), "dc1");
    step(0, 1, 1, 0, 24'h000000, 0, all3(10'h100), "dc2");
    blank(2'b00, "dc_blank");

    step(0, 1, 0, 0, 24'hffffff, 0, all3(10'h200), "xnor");
    blank(2'b01, "xnor_blank");

    step(0, 1, 0, 0, 24'h000000, 0, all3(10'h100), "cr0");
    step(0, 1, 0, 0, 24'h000000, 0, all3(10'h3ff), "cr1");
    step(0, 1, 0, 0, 24'h000000, 0, all3(10'h100), "cr2");
    blank(2'b00, "cr_drop");
    step(0, 1, 0, 0, 24'h000000, 0, all3(10'h100), "cr_resume");
    blank(2'b00, "cr_blank");

    step(0, 1, 0, 0, 24'h000000, 0, all3(10'h100), "mr0");
    step(0, 1, 0, 0, 24'h000000, 0, all3(10'h354), "mr_discard");
    step(1, 1, 1, 1, 24'h000000, 0, all3(10'h354), "mr_rst");
    step(0, 1, 0, 0, 24'h000000, 0, all3(10'h100), "mr_resume");
    blank(2'b00, "mr_blank");

    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 6; k++)
        blank({1'b1, k == 4}, "rt_vblank");
      for (int y = 0; y < 4; y++) begin
        for (int x = 0; x < 4; x++) begin
          v  = 8'(x ^ y);
          px = {v * 8'h55, v + 8'h1c, (v << 4) | 8'(x)};
          step(0, 1, 0, 0, px, 1, 30'h0, "rt_pixel");
        end
        blank(2'b01, "rt_hsync");
        blank(2'b00, "rt_hblank");
      end
    end

    for (int i = 0; i < 10 && q.size() != 0; i++)
      @(negedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
